// File: rtl/nav_arb.sv
// nav_arb: shares the navigate block between the host command processor
// (HOST) and the maze solver (SOL). It captures each requester's
// heading/move request and grants one owner, alternating when both are
// waiting. It issues a single start pulse, then waits for mv_cmplt and
// routes the completion pulse back to the owner only. A watchdog drops
// moves that never complete.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no owner; grant a pending requester if any
//   S_ISSUE | one cycle: start pulse to navigate, retire owner's pending
//   S_WAIT  | waiting for mv_cmplt or watchdog terminal count
module nav_arb #(
    parameter int unsigned           TMO_W   = 24,
    parameter logic [TMO_W-1:0]      TMO_CYC = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_strt_hdng,
    input  logic        host_strt_mv,
    input  logic [11:0] host_hdng,
    input  logic        host_stp_lft,
    input  logic        host_stp_rght,
    input  logic        sol_strt_hdng,
    input  logic        sol_strt_mv,
    input  logic [11:0] sol_hdng,
    input  logic        sol_stp_lft,
    input  logic        sol_stp_rght,
    input  logic        mv_cmplt,
    output logic        strt_hdng,
    output logic        strt_mv,
    output logic [11:0] dsrd_hdng,
    output logic        stp_lft,
    output logic        stp_rght,
    output logic        host_cmplt,
    output logic        sol_mv_cmplt,
    output logic [1:0]  owner,
    output logic        busy,
    output logic        nav_tmo
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_HOST = 2'b01;
    localparam logic [1:0] OWN_SOL  = 2'b10;

    state_t            state, state_nxt;

    logic              host_v, host_is_hdng, host_sl, host_sr;
    logic [11:0]       host_hdng_q;
    logic              sol_v, sol_is_hdng, sol_sl, sol_sr;
    logic [11:0]       sol_hdng_q;

    logic              last_sol;
    logic              is_hdng_q;
    logic [1:0]        owner_q;
    logic [11:0]       dsrd_hdng_q;
    logic              stp_lft_q, stp_rght_q;
    logic              host_cmplt_q, sol_cmplt_q;

    logic [TMO_W-1:0]  wdog_cnt;
    logic              wdog_tc;
    logic              grant_any, grant_sol;
    logic              host_req, sol_req;

    assign host_req  = host_strt_hdng | host_strt_mv;
    assign sol_req   = sol_strt_hdng  | sol_strt_mv;
    assign grant_any = host_v | sol_v;
    // SOL wins only when HOST is idle or HOST had the previous turn.
    assign grant_sol = sol_v & (~host_v | ~last_sol);
    // Down-counter reaches zero exactly TMO_CYC cycles into WAIT.
    assign wdog_tc   = (wdog_cnt == '0);

    // HOST pending request: a pulse (re)loads it, issuing the owner retires it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_v       <= 1'b0;
            host_is_hdng <= 1'b0;
            host_hdng_q  <= 12'h000;
            host_sl      <= 1'b0;
            host_sr      <= 1'b0;
        end else if (host_req) begin
            host_v       <= 1'b1;
            host_is_hdng <= host_strt_hdng;
            host_hdng_q  <= host_hdng;
            host_sl      <= host_stp_lft;
            host_sr      <= host_stp_rght;
        end else if (state == S_ISSUE && owner_q == OWN_HOST) begin
            host_v       <= 1'b0;
        end
    end

    // SOL pending request, same rules as HOST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sol_v       <= 1'b0;
            sol_is_hdng <= 1'b0;
            sol_hdng_q  <= 12'h000;
            sol_sl      <= 1'b0;
            sol_sr      <= 1'b0;
        end else if (sol_req) begin
            sol_v       <= 1'b1;
            sol_is_hdng <= sol_strt_hdng;
            sol_hdng_q  <= sol_hdng;
            sol_sl      <= sol_stp_lft;
            sol_sr      <= sol_stp_rght;
        end else if (state == S_ISSUE && owner_q == OWN_SOL) begin
            sol_v       <= 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; completion and timeout both return to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_any) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (mv_cmplt || wdog_tc) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant datapath: payload held from grant until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= OWN_NONE;
            dsrd_hdng_q <= 12'h000;
            stp_lft_q   <= 1'b0;
            stp_rght_q  <= 1'b0;
            is_hdng_q   <= 1'b0;
            last_sol    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        owner_q     <= grant_sol ? OWN_SOL : OWN_HOST;
                        dsrd_hdng_q <= grant_sol ? sol_hdng_q  : host_hdng_q;
                        stp_lft_q   <= grant_sol ? sol_sl      : host_sl;
                        stp_rght_q  <= grant_sol ? sol_sr      : host_sr;
                        is_hdng_q   <= grant_sol ? sol_is_hdng : host_is_hdng;
                    end
                end
                S_ISSUE: last_sol <= (owner_q == OWN_SOL);
                S_WAIT:  if (mv_cmplt || wdog_tc) owner_q <= OWN_NONE;
                default: owner_q <= OWN_NONE;
            endcase
        end
    end

    // Watchdog: loaded on issue, counts down in WAIT, holds at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wdog_cnt <= TMO_CYC - TMO_W'(1);
        end else if (state == S_WAIT && !wdog_tc) begin
            wdog_cnt <= wdog_cnt - TMO_W'(1);
        end
    end

    // Completion pulses go only to the current owner, one cycle after mv_cmplt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_cmplt_q <= 1'b0;
            sol_cmplt_q  <= 1'b0;
        end else begin
            host_cmplt_q <= (state == S_WAIT) && mv_cmplt && (owner_q == OWN_HOST);
            sol_cmplt_q  <= (state == S_WAIT) && mv_cmplt && (owner_q == OWN_SOL);
        end
    end

    // Output decode; timeout fires in the terminal cycle unless mv_cmplt arrives.
    always_comb begin
        strt_hdng    = 1'b0;
        strt_mv      = 1'b0;
        nav_tmo      = 1'b0;
        busy         = (state != S_IDLE);
        owner        = owner_q;
        dsrd_hdng    = dsrd_hdng_q;
        stp_lft      = stp_lft_q;
        stp_rght     = stp_rght_q;
        host_cmplt   = host_cmplt_q;
        sol_mv_cmplt = sol_cmplt_q;
        if (state == S_ISSUE) begin
            strt_hdng = is_hdng_q;
            strt_mv   = ~is_hdng_q;
        end
        if (state == S_WAIT && wdog_tc && !mv_cmplt) begin
            nav_tmo = 1'b1;
        end
    end

endmodule

// File: tb/tb_nav_arb.sv
// tb_nav_arb: directed test of nav_arb with a short watchdog (16 cycles).
// Inputs change 1 time unit after a rising edge; outputs are read there.
module tb_nav_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_strt_hdng = 1'b0, host_strt_mv = 1'b0;
    logic [11:0] host_hdng = 12'h000;
    logic        host_stp_lft = 1'b0, host_stp_rght = 1'b0;
    logic        sol_strt_hdng = 1'b0, sol_strt_mv = 1'b0;
    logic [11:0] sol_hdng = 12'h000;
    logic        sol_stp_lft = 1'b0, sol_stp_rght = 1'b0;
    logic        mv_cmplt = 1'b0;
    logic        strt_hdng, strt_mv, stp_lft, stp_rght;
    logic [11:0] dsrd_hdng;
    logic        host_cmplt, sol_mv_cmplt, busy, nav_tmo;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    nav_arb #(.TMO_W(24), .TMO_CYC(24'd16)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_strt_hdng(host_strt_hdng), .host_strt_mv(host_strt_mv),
        .host_hdng(host_hdng), .host_stp_lft(host_stp_lft), .host_stp_rght(host_stp_rght),
        .sol_strt_hdng(sol_strt_hdng), .sol_strt_mv(sol_strt_mv),
        .sol_hdng(sol_hdng), .sol_stp_lft(sol_stp_lft), .sol_stp_rght(sol_stp_rght),
        .mv_cmplt(mv_cmplt),
        .strt_hdng(strt_hdng), .strt_mv(strt_mv), .dsrd_hdng(dsrd_hdng),
        .stp_lft(stp_lft), .stp_rght(stp_rght),
        .host_cmplt(host_cmplt), .sol_mv_cmplt(sol_mv_cmplt),
        .owner(owner), .busy(busy), .nav_tmo(nav_tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Pulse mv_cmplt for one cycle; returns in the cycle after it.
    task automatic cmplt_pulse();
        mv_cmplt = 1'b1;
        tick(1);
        mv_cmplt = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "simulation time limit");
    end

    initial begin
        tick(2);
        check("rst_busy",  busy, 0);
        check("rst_owner", owner, 0);
        check("rst_dsrd",  dsrd_hdng, 12'h000);
        check("rst_strt",  {strt_hdng, strt_mv, stp_lft, stp_rght, host_cmplt, sol_mv_cmplt, nav_tmo}, 0);
        rst_n = 1'b1;
        tick(3);

        // HOST heading: pulse at N, start at N+2, completion at N+10 -> pulse at N+11.
        host_hdng = 12'h400; host_strt_hdng = 1'b1;
        tick(1);
        host_strt_hdng = 1'b0;
        check("t1_n1_strt", strt_hdng, 0);
        tick(1);
        check("t1_strt_hdng", strt_hdng, 1);
        check("t1_strt_mv",   strt_mv, 0);
        check("t1_dsrd",      dsrd_hdng, 12'h400);
        check("t1_owner",     owner, 2'b01);
        tick(1);
        check("t1_one_pulse", strt_hdng, 0);
        tick(7);
        cmplt_pulse();
        check("t1_host_cmplt", host_cmplt, 1);
        check("t1_sol_cmplt",  sol_mv_cmplt, 0);
        check("t1_busy",       busy, 0);
        check("t1_owner_idle", owner, 0);
        tick(1);
        check("t1_cmplt_once", host_cmplt, 0);
        check("t1_dsrd_hold",  dsrd_hdng, 12'h400);

        // Simultaneous moves after reset: HOST first, then SOL with its stop flags.
        do_reset();
        host_strt_mv = 1'b1; host_stp_lft = 1'b1; host_hdng = 12'h111;
        sol_strt_mv = 1'b1; sol_stp_rght = 1'b1; sol_hdng = 12'h123;
        tick(1);
        host_strt_mv = 1'b0; sol_strt_mv = 1'b0;
        host_stp_lft = 1'b0; sol_stp_rght = 1'b0;
        tick(1);
        check("t2_host_strt", strt_mv, 1);
        check("t2_host_own",  owner, 2'b01);
        check("t2_host_stp",  {stp_lft, stp_rght}, 2'b10);
        tick(3);
        cmplt_pulse();
        check("t2_host_cmplt", host_cmplt, 1);
        check("t2_gap",        strt_mv, 0);
        tick(1);
        check("t2_sol_strt", strt_mv, 1);
        check("t2_sol_own",  owner, 2'b10);
        check("t2_sol_stp",  {stp_lft, stp_rght}, 2'b01);
        check("t2_sol_dsrd", dsrd_hdng, 12'h123);
        tick(2);
        cmplt_pulse();
        check("t2_sol_cmplt",  sol_mv_cmplt, 1);
        check("t2_no_host",    host_cmplt, 0);

        // SOL request while HOST waits: held off until mv_cmplt + 2.
        tick(2);
        host_strt_mv = 1'b1;
        tick(1);
        host_strt_mv = 1'b0;
        tick(1);
        check("t3_host_strt", strt_mv, 1);
        tick(1);
        sol_strt_mv = 1'b1;
        tick(1);
        sol_strt_mv = 1'b0;
        tick(3);
        check("t3_held_off", {strt_mv, strt_hdng}, 0);
        check("t3_still_host", owner, 2'b01);
        cmplt_pulse();
        check("t3_m1", strt_mv, 0);
        tick(1);
        check("t3_sol_strt", strt_mv, 1);
        check("t3_sol_own",  owner, 2'b10);
        tick(1);
        cmplt_pulse();
        check("t3_sol_cmplt", sol_mv_cmplt, 1);

        // Watchdog: no completion -> nav_tmo at ISSUE+16, nothing to HOST.
        tick(2);
        host_strt_mv = 1'b1;
        tick(1);
        host_strt_mv = 1'b0;
        tick(1);
        check("t4_issue", strt_mv, 1);
        tick(15);
        check("t4_early", nav_tmo, 0);
        tick(1);
        check("t4_tmo",      nav_tmo, 1);
        check("t4_tmo_busy", busy, 1);
        tick(1);
        check("t4_tmo_once", nav_tmo, 0);
        check("t4_no_cmplt", host_cmplt, 0);
        check("t4_owner",    owner, 0);
        check("t4_idle",     busy, 0);

        // Completion on the terminal cycle wins over the timeout.
        tick(1);
        host_strt_mv = 1'b1;
        tick(1);
        host_strt_mv = 1'b0;
        tick(1);
        check("t4b_issue", strt_mv, 1);
        tick(16);
        mv_cmplt = 1'b1;
        #1;
        check("t4b_no_tmo", nav_tmo, 0);
        tick(1);
        mv_cmplt = 1'b0;
        #1;
        check("t4b_cmplt", host_cmplt, 1);
        check("t4b_tmo_after", nav_tmo, 0);
        check("t4b_owner", owner, 0);

        // mv_cmplt while idle is ignored.
        tick(2);
        cmplt_pulse();
        check("t4c_idle_cmplt", {host_cmplt, sol_mv_cmplt}, 0);

        // SOL heading overwritten while HOST owns: only 12'hC00 is issued, once.
        tick(1);
        host_strt_mv = 1'b1;
        tick(1);
        host_strt_mv = 1'b0;
        tick(1);
        check("t5_host_strt", strt_mv, 1);
        tick(1);
        sol_hdng = 12'h400; sol_strt_hdng = 1'b1;
        tick(1);
        sol_hdng = 12'hC00;
        tick(1);
        sol_strt_hdng = 1'b0;
        tick(1);
        cmplt_pulse();
        check("t5_gap", strt_hdng, 0);
        tick(1);
        check("t5_sol_hdng", strt_hdng, 1);
        check("t5_sol_dsrd", dsrd_hdng, 12'hC00);
        check("t5_sol_own",  owner, 2'b10);
        tick(1);
        cmplt_pulse();
        check("t5_sol_cmplt", sol_mv_cmplt, 1);
        tick(1);
        check("t5_once", {busy, strt_hdng, strt_mv}, 0);

        // Same-cycle heading + move: heading wins.
        host_hdng = 12'h0AB; host_strt_hdng = 1'b1; host_strt_mv = 1'b1;
        tick(1);
        host_strt_hdng = 1'b0; host_strt_mv = 1'b0;
        tick(1);
        check("t5b_hdng", {strt_hdng, strt_mv}, 2'b10);
        check("t5b_dsrd", dsrd_hdng, 12'h0AB);
        tick(1);
        cmplt_pulse();
        check("t5b_cmplt", host_cmplt, 1);
        tick(1);
        check("t5b_no_mv", {busy, strt_mv}, 0);

        // Reset in WAIT with SOL pending: everything clears and stays quiet.
        host_strt_mv = 1'b1; host_stp_rght = 1'b1;
        tick(1);
        host_strt_mv = 1'b0; host_stp_rght = 1'b0;
        tick(2);
        sol_strt_mv = 1'b1;
        tick(1);
        sol_strt_mv = 1'b0;
        tick(1);
        check("t6_wait_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_outs", {strt_hdng, strt_mv, stp_lft, stp_rght, host_cmplt,
                              sol_mv_cmplt, busy, nav_tmo}, 0);
        check("t6_rst_owner", owner, 0);
        check("t6_rst_dsrd",  dsrd_hdng, 12'h000);
        tick(1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("t6_no_strt", {strt_hdng, strt_mv, busy}, 0);
        end
        cmplt_pulse();
        check("t6_late_cmplt", {host_cmplt, sol_mv_cmplt}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
